// File: rtl/corr_sequencer_pkg.sv
// Shared defaults and FSM encoding for the correlator sample sequencer.
// Derived widths are computed here so every file agrees on them.
package corr_sequencer_pkg;

    localparam int RADIOS_DEF = 32;
    localparam int TRATE_DEF  = 30;
    localparam int LOOP0_DEF  = 3;
    localparam int ACCUM_DEF  = 64;
    localparam int TBITS_DEF  = $clog2(TRATE_DEF);
    localparam int ABITS_DEF  = $clog2(ACCUM_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/slice_counter.sv
// Modulo-N counter that advances on inc, flagging the final count and
// the final count of every CHUNK-long group (CHUNK must divide N).
module slice_counter
    import corr_sequencer_pkg::*;
#(
    parameter int N     = TRATE_DEF,
    parameter int CHUNK = LOOP0_DEF,
    localparam int W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         boundary
);

    assign at_max = (count == W'(N - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= at_max ? '0 : count + W'(1);
        end
    end

    // A separate chunk counter avoids a modulo operator on the main count.
    if (CHUNK > 1) begin : g_chunk
        localparam int CW = $clog2(CHUNK);
        logic [CW-1:0] chunk;

        assign boundary = (chunk == CW'(CHUNK - 1));

        always_ff @(posedge clock) begin
            if (reset) begin
                chunk <= '0;
            end else if (inc) begin
                chunk <= (boundary || at_max) ? '0 : chunk + CW'(1);
            end
        end
    end else begin : g_unit
        assign boundary = 1'b1;
    end

endmodule

// File: rtl/corr_sequencer.sv
// Holds each accepted IQ sample and sweeps it over TRATE timeslices,
// producing the first/next/emit/last strobes for ACCUM-sample windows.
module corr_sequencer
    import corr_sequencer_pkg::*;
#(
    parameter int RADIOS = RADIOS_DEF,
    parameter int TRATE  = TRATE_DEF,
    parameter int LOOP0  = LOOP0_DEF,
    parameter int ACCUM  = ACCUM_DEF,
    localparam int TBITS = $clog2(TRATE),
    localparam int ABITS = $clog2(ACCUM)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [RADIOS-1:0] sigi_i,
    input  logic [RADIOS-1:0] sigq_i,
    output logic              valid_o,
    output logic              first_o,
    output logic              next_o,
    output logic              emit_o,
    output logic              last_o,
    output logic [TBITS-1:0]  addr_o,
    output logic [RADIOS-1:0] sigi_o,
    output logic [RADIOS-1:0] sigq_o,
    output logic              busy_o
);

    state_t           state, state_nx;
    logic             ready_c;
    logic             accept;
    logic             sweeping;
    logic [TBITS-1:0] t_count;
    logic             t_max, t_bnd;
    logic [ABITS-1:0] k_count;
    logic             k_max, k_bnd;

    assign sweeping = (state == ST_SWEEP);
    assign accept   = valid_i & ready_o;

    // t advances every sweep slice; k advances once per completed sweep.
    slice_counter #(.N(TRATE), .CHUNK(LOOP0)) u_tslice (
        .clock    (clock),
        .reset    (reset),
        .inc      (sweeping),
        .count    (t_count),
        .at_max   (t_max),
        .boundary (t_bnd)
    );

    slice_counter #(.N(ACCUM), .CHUNK(ACCUM)) u_ksample (
        .clock    (clock),
        .reset    (reset),
        .inc      (sweeping & t_max),
        .count    (k_count),
        .at_max   (k_max),
        .boundary (k_bnd)
    );

    always_comb begin
        state_nx = state;
        ready_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_c = enable_i;
                if (accept) state_nx = ST_SWEEP;
            end
            ST_SWEEP: begin
                // Only a window boundary consults enable_i.
                ready_c = t_max & (k_max ? enable_i : 1'b1);
                if (t_max) begin
                    if (accept)     state_nx = ST_SWEEP;
                    else if (k_max) state_nx = ST_IDLE;
                    else            state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ready_c = 1'b1;
                if (accept) state_nx = ST_SWEEP;
            end
            default: state_nx = ST_IDLE;
        endcase
        ready_o = ready_c & ~reset;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            sigi_o <= sigi_i;
            sigq_o <= sigq_i;
        end
    end

    assign valid_o = sweeping;
    assign addr_o  = t_count;
    assign first_o = sweeping & (k_count == '0);
    assign next_o  = sweeping & t_bnd;
    assign emit_o  = sweeping & t_bnd & k_bnd;
    assign last_o  = sweeping & t_max & k_max;
    assign busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_corr_sequencer.sv
// Randomized scoreboard bench for corr_sequencer (TRATE=30, LOOP0=3, ACCUM=4).
module tb_corr_sequencer;

    localparam int RADIOS = 32;
    localparam int TRATE  = 30;
    localparam int LOOP0  = 3;
    localparam int ACCUM  = 4;
    localparam int TBITS  = $clog2(TRATE);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable_i = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [RADIOS-1:0] sigi_i = '0;
    logic [RADIOS-1:0] sigq_i = '0;
    logic              valid_o, first_o, next_o, emit_o, last_o, busy_o;
    logic [TBITS-1:0]  addr_o;
    logic [RADIOS-1:0] sigi_o, sigq_o;

    corr_sequencer #(.RADIOS(RADIOS), .TRATE(TRATE), .LOOP0(LOOP0), .ACCUM(ACCUM)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable_i (enable_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sigi_i   (sigi_i),
        .sigq_i   (sigq_i),
        .valid_o  (valid_o),
        .first_o  (first_o),
        .next_o   (next_o),
        .emit_o   (emit_o),
        .last_o   (last_o),
        .addr_o   (addr_o),
        .sigi_o   (sigi_o),
        .sigq_o   (sigq_o),
        .busy_o   (busy_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [TBITS-1:0]  addr;
        logic              first;
        logic              next;
        logic              emit;
        logic              last;
        logic [RADIOS-1:0] si;
        logic [RADIOS-1:0] sq;
    } beat_t;

    beat_t exp_q[$];
    int    kcount   = 0;   // samples accepted so far in the current window
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: one accepted sample expands to TRATE expected slices.
    function automatic void push_sample(int k, logic [RADIOS-1:0] si, logic [RADIOS-1:0] sq);
        beat_t b;
        for (int t = 0; t < TRATE; t++) begin
            b.addr  = TBITS'(t);
            b.first = (k == 0);
            b.next  = ((t % LOOP0) == LOOP0 - 1);
            b.emit  = b.next && (k == ACCUM - 1);
            b.last  = (k == ACCUM - 1) && (t == TRATE - 1);
            b.si    = si;
            b.sq    = sq;
            exp_q.push_back(b);
        end
    endfunction

    // Monitor: outputs are registered, so they are sampled on the falling edge.
    initial begin
        beat_t a, e;
        @(posedge clock);
        forever begin
            @(negedge clock);
            check("busy", 128'(busy_o), 128'((exp_q.size() != 0) || (kcount != 0)));
            if (exp_q.size() == 0) begin
                check("valid_idle", 128'(valid_o), 128'(0));
                check("strobes_idle", 128'({first_o, next_o, emit_o, last_o, addr_o}), 128'(0));
            end else begin
                e = exp_q.pop_front();
                a.addr  = addr_o;
                a.first = first_o;
                a.next  = next_o;
                a.emit  = emit_o;
                a.last  = last_o;
                a.si    = sigi_o;
                a.sq    = sigq_o;
                check("valid_sweep", 128'(valid_o), 128'(1));
                check("beat", 128'(a), 128'(e));
            end
        end
    end

    // Inputs are changed just after the falling edge, with fresh random IQ every cycle.
    task automatic drive_cycle(input bit v, input bit en);
        bit exp_ready;
        @(negedge clock);
        #1;
        valid_i  = v;
        enable_i = en;
        sigi_i   = $urandom;
        sigq_i   = $urandom;
        #1;
        if (reset)                  exp_ready = 1'b0;
        else if (exp_q.size() != 0) exp_ready = 1'b0;
        else if (kcount != 0)       exp_ready = 1'b1;
        else                        exp_ready = en;
        check("ready", 128'(ready_o), 128'(exp_ready));
        if (v && ready_o && !reset) begin
            push_sample(kcount, sigi_i, sigq_i);
            kcount = (kcount + 1) % ACCUM;
        end
    endtask

    task automatic apply_reset(input int cycles);
        reset   = 1'b1;
        valid_i = 1'b0;
        exp_q.delete();
        kcount  = 0;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bit found;
        bit en;

        apply_reset(3);

        // Continuous samples: two full windows and the start of a third.
        for (int i = 0; i < 250; i++) drive_cycle(1'b1, 1'b1);
        apply_reset(2);

        // Enable dropped at cycle 40 of a window; it must still complete.
        for (int i = 0; i < 40; i++)  drive_cycle(1'b1, 1'b1);
        for (int i = 0; i < 150; i++) drive_cycle(1'b1, 1'b0);

        // Single sample, 50-cycle gap, then another sample (k=1, first_o=0).
        drive_cycle(1'b1, 1'b1);
        for (int i = 0; i < 50; i++) drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) drive_cycle(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) drive_cycle(1'b1, 1'b0);

        // Sparse and mixed random traffic with enable toggling.
        en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 36) == 0) en = ~en;
            drive_cycle($urandom_range(0, 99) < ((i < 500) ? 8 : 60), en);
        end

        // Reset while addr 15 of the window's final sweep is on the outputs.
        apply_reset(2);
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            drive_cycle(1'b1, 1'b1);
            if (kcount == 0 && exp_q.size() == TRATE - 16) found = 1'b1;
        end
        check("reset_point_found", 128'(found), 128'(1));
        if (found) apply_reset(2);
        for (int i = 0; i < 40; i++) drive_cycle(1'b0, 1'b0);

        // Drain anything still in flight, then confirm nothing was left unseen.
        for (int i = 0; i < 130; i++) drive_cycle(1'b0, 1'b0);
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
